dte_ebus_slave: RTL and testbench

- EBUS-side I/O slave for the DTE console front-end. It decodes KL10 EBUS I/O cycles (CONO/CONI/DATAO/DATAI) addressed to the DTE controller number.
- It queues DATAO words toward the front-end (DPI tick side), presents front-end words to the KL for DATAI, and manages doorbell/PI interrupt state.
- It sits between the EBUS and the DTE core.

---
 rtl/dte_ebus_slave.sv | 203 ++++++++++++++++++++
 tb/tb_dte_ebus_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dte_ebus_slave.sv
// dte_ebus_slave
// EBUS-side I/O slave for the DTE console front-end. Decodes KL10 EBUS
// CONO/CONI/DATAO/DATAI cycles addressed to CTL_NUM. It queues DATAO words
// toward the front-end, presents a front-end word for DATAI, and keeps the
// doorbell / PI interrupt state.
//
// Ports
//   clk, CROBAR           clock, synchronous active-high reset
//   ebus_cs/func/demand   KL request (controller, function, demand)
//   ebus_data_in          KL-driven data for CONO/DATAO
//   ebus_xfer             slave transfer acknowledge
//   ebus_data_out/_oe     CONI/DATAI return data (zero when not driving)
//   pi_req, pi_level      interrupt request and assigned PI level
//   fe_rd_*               DATAO FIFO head toward the front-end
//   fe_wr_*               to-10 holding register loaded by the front-end
//   fe_bell_11/_ack       to-11 doorbell and its front-end clear
//   fe_bell_10            front-end rings the to-10 doorbell
module dte_ebus_slave #(
  parameter logic [6:0] CTL_NUM = 7'o10,
  parameter int         DEPTH   = 4
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic [6:0]  ebus_cs,
  input  logic [2:0]  ebus_func,
  input  logic        ebus_demand,
  input  logic [35:0] ebus_data_in,
  output logic        ebus_xfer,
  output logic [35:0] ebus_data_out,
  output logic        ebus_data_oe,
  output logic        pi_req,
  output logic [2:0]  pi_level,
  output logic        fe_rd_valid,
  output logic [35:0] fe_rd_data,
  input  logic        fe_rd_ready,
  input  logic        fe_wr_valid,
  input  logic [35:0] fe_wr_data,
  output logic        fe_wr_full,
  output logic        fe_bell_11,
  input  logic        fe_bell_ack,
  input  logic        fe_bell_10
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_STALL  = 2'd2;
  localparam logic [1:0] S_XFER   = 2'd3;

  localparam logic [1:0] F_CONO  = 2'd0;
  localparam logic [1:0] F_CONI  = 2'd1;
  localparam logic [1:0] F_DATAO = 2'd2;
  localparam logic [1:0] F_DATAI = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    r_func;
  logic [35:0]   r_cmd_data;
  logic          r_xfer;
  logic          r_data_oe;
  logic [35:0]   r_data_out;
  logic [2:0]    r_pia;
  logic          r_bell_10;
  logic          r_bell_11;
  logic          r_pi_req;
  logic [35:0]   r_hold_data;
  logic          r_hold_full;
  logic [35:0]   r_fifo_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [1:0]    w_state_next;
  logic          w_req_ok;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_pop;
  logic          w_act;
  logic          w_push;
  logic          w_cono;
  logic          w_datai;
  logic [35:0]   w_coni_word;
  logic [35:0]   w_datai_word;

  assign w_req_ok     = ebus_demand && (ebus_cs == CTL_NUM) && !ebus_func[2];
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == FULL_CNT);
  assign w_pop        = !w_fifo_empty && fe_rd_ready;

  // Next-state logic. A stalled DATAO may complete in the very cycle a pop
  // frees a slot: the push and pop then happen together.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req_ok) w_state_next = S_DECODE;
      S_DECODE: begin
        if (r_func == F_DATAO && w_fifo_full) w_state_next = S_STALL;
        else                                  w_state_next = S_XFER;
      end
      S_STALL:  if (!w_fifo_full || w_pop) w_state_next = S_XFER;
      S_XFER:   if (!ebus_demand) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // The single action cycle: leaving DECODE or STALL for XFER.
  assign w_act   = (r_state == S_DECODE || r_state == S_STALL) && (w_state_next == S_XFER);
  assign w_push  = w_act && (r_func == F_DATAO);
  assign w_cono  = w_act && (r_func == F_CONO);
  assign w_datai = w_act && (r_func == F_DATAI);

  // Bit 5 (overflow error) is reserved and always reads 0.
  assign w_coni_word  = {27'd0, w_fifo_full, w_fifo_empty, r_hold_full, 1'b0,
                         r_bell_10, r_bell_11, r_pia};
  assign w_datai_word = r_hold_full ? r_hold_data : 36'd0;

  // Bus handshake. xfer/oe are registered from the state so they appear one
  // cycle after XFER is entered and drop one cycle after it is left.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_state    <= S_IDLE;
      r_func     <= F_CONO;
      r_cmd_data <= '0;
      r_xfer     <= 1'b0;
      r_data_oe  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state   <= w_state_next;
      r_xfer    <= (r_state == S_XFER);
      // CONI and DATAI are the odd function codes.
      r_data_oe <= (r_state == S_XFER) && r_func[0];
      if (r_state == S_IDLE && w_req_ok) begin
        r_func     <= ebus_func[1:0];
        r_cmd_data <= ebus_data_in;
      end
      if (w_act && r_func == F_CONI)  r_data_out <= w_coni_word;
      if (w_datai)                    r_data_out <= w_datai_word;
    end
  end

  // DATAO FIFO storage (no reset needed; validity comes from r_count).
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= r_cmd_data;
  end

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Holding register, doorbells, PI. Front-end loads/sets beat the
  // EBUS-side clears when both land on the same edge.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_pia       <= '0;
      r_bell_10   <= 1'b0;
      r_bell_11   <= 1'b0;
      r_pi_req    <= 1'b0;
    end else begin
      if (fe_wr_valid) begin
        r_hold_data <= fe_wr_data;
        r_hold_full <= 1'b1;
      end else if (w_datai) begin
        r_hold_full <= 1'b0;
      end

      if (w_cono) r_pia <= r_cmd_data[2:0];

      if (fe_bell_10)                    r_bell_10 <= 1'b1;
      else if (w_cono && r_cmd_data[4])  r_bell_10 <= 1'b0;

      if (w_cono && r_cmd_data[3])       r_bell_11 <= 1'b1;
      else if (fe_bell_ack)              r_bell_11 <= 1'b0;

      r_pi_req <= r_bell_10 && (r_pia != 3'd0);
    end
  end

  assign ebus_xfer     = r_xfer;
  assign ebus_data_oe  = r_data_oe;
  assign ebus_data_out = r_data_oe ? r_data_out : 36'd0;
  assign pi_req        = r_pi_req;
  assign pi_level      = r_pia;
  assign fe_rd_valid   = !w_fifo_empty;
  assign fe_rd_data    = w_fifo_empty ? 36'd0 : r_fifo_mem[r_rd_ptr];
  assign fe_wr_full    = r_hold_full;
  assign fe_bell_11    = r_bell_11;

endmodule

// File: tb/tb_dte_ebus_slave.sv
// Directed testbench for dte_ebus_slave.
module tb_dte_ebus_slave;

  logic        clk = 1'b0;
  logic        CROBAR;
  logic [6:0]  ebus_cs;
  logic [2:0]  ebus_func;
  logic        ebus_demand;
  logic [35:0] ebus_data_in;
  logic        ebus_xfer;
  logic [35:0] ebus_data_out;
  logic        ebus_data_oe;
  logic        pi_req;
  logic [2:0]  pi_level;
  logic        fe_rd_valid;
  logic [35:0] fe_rd_data;
  logic        fe_rd_ready;
  logic        fe_wr_valid;
  logic [35:0] fe_wr_data;
  logic        fe_wr_full;
  logic        fe_bell_11;
  logic        fe_bell_ack;
  logic        fe_bell_10;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] CONO = 3'd0, CONI = 3'd1, DATAO = 3'd2, DATAI = 3'd3;

  dte_ebus_slave #(.CTL_NUM(7'o10), .DEPTH(4)) dut (
    .clk(clk), .CROBAR(CROBAR),
    .ebus_cs(ebus_cs), .ebus_func(ebus_func), .ebus_demand(ebus_demand),
    .ebus_data_in(ebus_data_in), .ebus_xfer(ebus_xfer),
    .ebus_data_out(ebus_data_out), .ebus_data_oe(ebus_data_oe),
    .pi_req(pi_req), .pi_level(pi_level),
    .fe_rd_valid(fe_rd_valid), .fe_rd_data(fe_rd_data), .fe_rd_ready(fe_rd_ready),
    .fe_wr_valid(fe_wr_valid), .fe_wr_data(fe_wr_data), .fe_wr_full(fe_wr_full),
    .fe_bell_11(fe_bell_11), .fe_bell_ack(fe_bell_ack), .fe_bell_10(fe_bell_10)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o, expected %0o", tag, obs, exp);
    end
  endtask

  // Drop demand and wait (bounded) for xfer to fall.
  task automatic release_bus();
    @(negedge clk);
    ebus_demand  = 1'b0;
    ebus_func    = 3'd0;
    ebus_data_in = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (!ebus_xfer) break;
    end
  endtask

  // Wait up to 'limit' edges for xfer; returns edge index (-1 if none).
  task automatic wait_xfer(input int limit, output int lat, output logic [35:0] rd, output logic oe);
    lat = -1; rd = '0; oe = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (ebus_xfer) begin
        lat = i; rd = ebus_data_out; oe = ebus_data_oe;
        break;
      end
    end
  endtask

  // Full EBUS cycle; checks latency (xfer at edge N+2), oe and returned data.
  task automatic op_chk(input string tag, input logic [2:0] fn, input logic [35:0] d,
                        input logic [35:0] exp_rd, input logic exp_oe);
    int          lat;
    logic [35:0] rd;
    logic        oe;
    @(negedge clk);
    ebus_cs = 7'o10; ebus_func = fn; ebus_data_in = d; ebus_demand = 1'b1;
    wait_xfer(40, lat, rd, oe);
    $display("op %s fn=%0d data=%0o lat=%0d rd=%0o oe=%0d", tag, fn, d, lat, rd, oe);
    chk({tag, "_lat"}, 36'(lat), 36'd2);
    chk({tag, "_oe"}, {35'd0, oe}, {35'd0, exp_oe});
    chk({tag, "_data"}, rd, exp_rd);
    release_bus();
  endtask

  // EBUS cycle with a front-end event pulsed exactly on the action edge (N+1).
  // sel: 0 = fe_bell_10, 1 = fe_bell_ack, 2 = fe_wr_valid with wd.
  task automatic op_pulse(input string tag, input logic [2:0] fn, input logic [35:0] d,
                          input int sel, input logic [35:0] wd, output logic [35:0] rd);
    int   lat;
    logic oe;
    @(negedge clk);
    ebus_cs = 7'o10; ebus_func = fn; ebus_data_in = d; ebus_demand = 1'b1;
    @(posedge clk);
    @(negedge clk);
    case (sel)
      0: fe_bell_10 = 1'b1;
      1: fe_bell_ack = 1'b1;
      default: begin fe_wr_valid = 1'b1; fe_wr_data = wd; end
    endcase
    @(posedge clk);
    @(negedge clk);
    fe_bell_10 = 1'b0; fe_bell_ack = 1'b0; fe_wr_valid = 1'b0; fe_wr_data = '0;
    wait_xfer(40, lat, rd, oe);
    $display("op %s fn=%0d data=%0o sel=%0d rd=%0o", tag, fn, d, sel, rd);
    chk({tag, "_xfer"}, {35'd0, lat >= 0}, 36'd1);
    release_bus();
  endtask

  task automatic pop1();
    @(negedge clk); fe_rd_ready = 1'b1;
    @(negedge clk); fe_rd_ready = 1'b0;
  endtask

  task automatic pulse(input int sel, input logic [35:0] wd);
    @(negedge clk);
    case (sel)
      0: fe_bell_10 = 1'b1;
      1: fe_bell_ack = 1'b1;
      default: begin fe_wr_valid = 1'b1; fe_wr_data = wd; end
    endcase
    @(negedge clk);
    fe_bell_10 = 1'b0; fe_bell_ack = 1'b0; fe_wr_valid = 1'b0; fe_wr_data = '0;
  endtask

  logic [35:0] words [5];
  logic [35:0] rd;
  logic        oe;
  int          lat;
  logic        seen_x, seen_oe;

  initial begin
    CROBAR = 1'b1; ebus_cs = '0; ebus_func = '0; ebus_demand = 1'b0; ebus_data_in = '0;
    fe_rd_ready = 1'b0; fe_wr_valid = 1'b0; fe_wr_data = '0; fe_bell_ack = 1'b0; fe_bell_10 = 1'b0;
    words[0] = 36'o100000000001; words[1] = 36'o200000000002; words[2] = 36'o300000000003;
    words[3] = 36'o400000000004; words[4] = 36'o500000000005;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_xfer", {35'd0, ebus_xfer}, 36'd0);
    chk("rst_oe", {35'd0, ebus_data_oe}, 36'd0);
    chk("rst_dout", ebus_data_out, 36'd0);
    chk("rst_pi", {32'd0, pi_req, pi_level}, 36'd0);
    chk("rst_fe", {33'd0, fe_rd_valid, fe_wr_full, fe_bell_11}, 36'd0);
    chk("rst_rdata", fe_rd_data, 36'd0);
    @(negedge clk); CROBAR = 1'b0;
    op_chk("rst_coni", CONI, '0, 36'o000000000200, 1'b1);

    // DATAO and drain
    op_chk("datao", DATAO, 36'o123456654321, 36'd0, 1'b0);
    chk("datao_valid", {35'd0, fe_rd_valid}, 36'd1);
    chk("datao_head", fe_rd_data, 36'o123456654321);
    pop1();
    chk("drain_empty", {35'd0, fe_rd_valid}, 36'd0);

    // Full FIFO stall
    for (int k = 0; k < 4; k++) op_chk("fill", DATAO, words[k], 36'd0, 1'b0);
    op_chk("full_coni", CONI, '0, 36'o000000000400, 1'b1);
    @(negedge clk);
    ebus_cs = 7'o10; ebus_func = DATAO; ebus_data_in = words[4]; ebus_demand = 1'b1;
    seen_x = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (ebus_xfer) seen_x = 1'b1; end
    chk("stall_no_xfer", {35'd0, seen_x}, 36'd0);
    chk("stall_head", fe_rd_data, words[0]);
    pop1();
    wait_xfer(10, lat, rd, oe);
    $display("op stall_release lat=%0d", lat);
    chk("stall_release", {35'd0, lat >= 0}, 36'd1);
    release_bus();
    for (int k = 1; k < 5; k++) begin
      chk("fifo_valid", {35'd0, fe_rd_valid}, 36'd1);
      chk("fifo_order", fe_rd_data, words[k]);
      pop1();
    end
    chk("fifo_drained", {35'd0, fe_rd_valid}, 36'd0);

    // Doorbells and PI
    op_chk("cono_pia", CONO, 36'o5, 36'd0, 1'b0);
    chk("pia_level", {33'd0, pi_level}, 36'd5);
    chk("pia_noreq", {35'd0, pi_req}, 36'd0);
    pulse(0, '0);
    chk("pi_lag", {35'd0, pi_req}, 36'd0);
    @(negedge clk);
    chk("pi_req_set", {35'd0, pi_req}, 36'd1);
    op_chk("bell_coni", CONI, '0, 36'o000000000225, 1'b1);
    op_pulse("bell10_win", CONO, 36'o25, 0, '0, rd);
    chk("bell10_setwins", {35'd0, pi_req}, 36'd1);
    op_chk("cono_clr10", CONO, 36'o25, 36'd0, 1'b0);
    chk("pi_req_clr", {35'd0, pi_req}, 36'd0);
    chk("pi_level_keep", {33'd0, pi_level}, 36'd5);
    op_chk("cono_ring11", CONO, 36'o15, 36'd0, 1'b0);
    chk("bell11_set", {35'd0, fe_bell_11}, 36'd1);
    pulse(1, '0);
    chk("bell11_ack", {35'd0, fe_bell_11}, 36'd0);
    op_pulse("bell11_win", CONO, 36'o15, 1, '0, rd);
    chk("bell11_setwins", {35'd0, fe_bell_11}, 36'd1);
    pulse(1, '0);
    chk("bell11_ack2", {35'd0, fe_bell_11}, 36'd0);

    // DATAI and holding register
    pulse(2, 36'o777000000001);
    chk("wr_full", {35'd0, fe_wr_full}, 36'd1);
    op_chk("hold_coni", CONI, '0, 36'o000000000305, 1'b1);
    op_chk("datai1", DATAI, '0, 36'o777000000001, 1'b1);
    chk("wr_cleared", {35'd0, fe_wr_full}, 36'd0);
    op_chk("datai_empty", DATAI, '0, 36'd0, 1'b1);
    pulse(2, 36'o111222333444);
    op_pulse("datai_race", DATAI, '0, 2, 36'o555666777000, rd);
    chk("race_old_data", rd, 36'o111222333444);
    chk("race_full", {35'd0, fe_wr_full}, 36'd1);
    op_chk("datai_new", DATAI, '0, 36'o555666777000, 1'b1);

    // Wrong address / bad function
    @(negedge clk);
    ebus_cs = 7'o11; ebus_func = DATAO; ebus_data_in = 36'o7; ebus_demand = 1'b1;
    seen_x = 1'b0; seen_oe = 1'b0;
    repeat (20) begin @(posedge clk); #1; seen_x |= ebus_xfer; seen_oe |= ebus_data_oe; end
    @(negedge clk); ebus_cs = 7'o10; ebus_func = 3'd5;
    repeat (5) begin @(posedge clk); #1; seen_x |= ebus_xfer; seen_oe |= ebus_data_oe; end
    $display("op wrong_addr xfer=%0d oe=%0d", seen_x, seen_oe);
    chk("wrong_xfer", {35'd0, seen_x}, 36'd0);
    chk("wrong_oe", {35'd0, seen_oe}, 36'd0);
    chk("wrong_nopush", {35'd0, fe_rd_valid}, 36'd0);
    release_bus();

    // Reset mid-cycle
    @(negedge clk);
    ebus_cs = 7'o10; ebus_func = CONI; ebus_data_in = '0; ebus_demand = 1'b1;
    wait_xfer(10, lat, rd, oe);
    chk("mid_xfer", {35'd0, lat >= 0}, 36'd1);
    @(negedge clk); CROBAR = 1'b1;
    @(posedge clk); #1;
    $display("op mid_reset xfer=%0d oe=%0d", ebus_xfer, ebus_data_oe);
    chk("mid_rst_xfer", {35'd0, ebus_xfer}, 36'd0);
    chk("mid_rst_oe", {35'd0, ebus_data_oe}, 36'd0);
    chk("mid_rst_pia", {33'd0, pi_level}, 36'd0);
    chk("mid_rst_wr", {35'd0, fe_wr_full}, 36'd0);
    @(negedge clk); CROBAR = 1'b0; ebus_demand = 1'b0;
    op_chk("post_rst_coni", CONI, '0, 36'o000000000200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
